// File: rtl/instr_fetch.sv
// instr_fetch: byte-serial instruction fetch sequencer for the S1C88 core.
// Reads opcode / opext / immediate bytes one at a time, steering the length
// decision through the external combinational decode block, and hands each
// complete instruction to execute through a valid/ready handshake.
// Optional feature: define IFETCH_PREFETCH_EN to add a one-byte prefetch
// buffer that fetches the next opcode while an instruction waits in VALID.
module instr_fetch #(
    parameter logic [23:0] RESET_PC = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_req,
    output logic [23:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [7:0]  fetch_data,
    output logic [7:0]  dec_opcode,
    output logic [7:0]  dec_opext,
    input  logic        need_opext,
    input  logic        need_imm,
    input  logic        imm_size,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [7:0]  instr_opext,
    output logic [15:0] instr_imm,
    output logic [2:0]  instr_len,
    output logic [23:0] instr_pc,
    input  logic        redirect,
    input  logic [23:0] redirect_pc
);

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_EXT,
        FETCH_IMM_LO,
        FETCH_IMM_HI,
        VALID,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    state_t      after_op;

    logic [23:0] pc;
    logic [23:0] drain_addr;
    logic [23:0] op_addr;
    logic [7:0]  opcode_q;
    logic [7:0]  opext_q;
    logic [15:0] imm_q;
    logic [2:0]  len_q;
    logic [23:0] instr_pc_q;

    logic        take_op;
    logic        take_ext;
    logic        take_lo;
    logic        take_hi;
    logic        pc_inc;
    logic        drain_start;

`ifdef IFETCH_PREFETCH_EN
    logic        buf_valid;
    logic [7:0]  buf_data;
    logic [23:0] buf_pc;
    logic        buf_fill;
    logic        buf_take;
`endif

    // Where to go once the opcode byte is known; decode answers in the same cycle.
    assign after_op = need_opext ? FETCH_EXT : (need_imm ? FETCH_IMM_LO : VALID);

`ifdef IFETCH_PREFETCH_EN
    assign dec_opcode = (state == FETCH_OP) ? fetch_data :
                        (state == VALID)    ? (buf_valid ? buf_data : fetch_data) :
                                              opcode_q;
`else
    assign dec_opcode = (state == FETCH_OP) ? fetch_data : opcode_q;
`endif
    assign dec_opext  = (state == FETCH_EXT) ? fetch_data : opext_q;

    // While draining, the bus still sees the abandoned address; pc already holds the target.
    assign fetch_addr   = (state == DRAIN) ? drain_addr : pc;
    assign instr_valid  = (state == VALID);
    assign instr_opcode = opcode_q;
    assign instr_opext  = opext_q;
    assign instr_imm    = imm_q;
    assign instr_len    = len_q;
    assign instr_pc     = instr_pc_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH_OP;
        else       state <= state_next;
    end

    // Next-state, bus request and byte-capture strobes; redirect overrides everything last.
    always_comb begin
        state_next  = state;
        fetch_req   = 1'b0;
        take_op     = 1'b0;
        take_ext    = 1'b0;
        take_lo     = 1'b0;
        take_hi     = 1'b0;
        pc_inc      = 1'b0;
        drain_start = 1'b0;
        op_addr     = pc;
`ifdef IFETCH_PREFETCH_EN
        buf_fill    = 1'b0;
        buf_take    = 1'b0;
`endif
        case (state)
            FETCH_OP: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    take_op    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = after_op;
                end
            end
            FETCH_EXT: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    take_ext   = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = need_imm ? FETCH_IMM_LO : VALID;
                end
            end
            FETCH_IMM_LO: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    take_lo    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = imm_size ? FETCH_IMM_HI : VALID;
                end
            end
            FETCH_IMM_HI: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    take_hi    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = VALID;
                end
            end
            VALID: begin
`ifdef IFETCH_PREFETCH_EN
                if (!buf_valid) begin
                    fetch_req = 1'b1;
                    if (fetch_ack) begin
                        pc_inc = 1'b1;
                        if (instr_ready) begin
                            take_op    = 1'b1;
                            state_next = after_op;
                        end else begin
                            buf_fill = 1'b1;
                        end
                    end else if (instr_ready) begin
                        state_next = FETCH_OP;
                    end
                end else if (instr_ready) begin
                    take_op    = 1'b1;
                    buf_take   = 1'b1;
                    op_addr    = buf_pc;
                    state_next = after_op;
                end
`else
                if (instr_ready) state_next = FETCH_OP;
`endif
            end
            DRAIN: begin
                fetch_req = 1'b1;
                if (fetch_ack) state_next = FETCH_OP;
            end
            default: state_next = FETCH_OP;
        endcase

        if (redirect) begin
            take_op  = 1'b0;
            take_ext = 1'b0;
            take_lo  = 1'b0;
            take_hi  = 1'b0;
            pc_inc   = 1'b0;
`ifdef IFETCH_PREFETCH_EN
            buf_fill = 1'b0;
            buf_take = 1'b0;
`endif
            if (state == DRAIN) begin
                state_next = fetch_ack ? FETCH_OP : DRAIN;
            end else if (fetch_req && !fetch_ack) begin
                state_next  = DRAIN;
                drain_start = 1'b1;
            end else begin
                state_next = FETCH_OP;
            end
        end
    end

    // Program counter, drain address and captured instruction fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            opcode_q   <= 8'h00;
            opext_q    <= 8'h00;
            imm_q      <= 16'h0000;
            len_q      <= 3'd1;
            instr_pc_q <= RESET_PC;
        end else begin
            if (redirect)    pc <= redirect_pc;
            else if (pc_inc) pc <= pc + 24'd1;
            if (drain_start) drain_addr <= pc;
            if (take_op) begin
                opcode_q   <= dec_opcode;
                opext_q    <= 8'h00;
                imm_q      <= 16'h0000;
                len_q      <= 3'd1;
                instr_pc_q <= op_addr;
            end
            if (take_ext) begin
                opext_q <= fetch_data;
                len_q   <= len_q + 3'd1;
            end
            if (take_lo) begin
                imm_q[7:0] <= fetch_data;
                len_q      <= len_q + 3'd1;
            end
            if (take_hi) begin
                imm_q[15:8] <= fetch_data;
                len_q       <= len_q + 3'd1;
            end
        end
    end

`ifdef IFETCH_PREFETCH_EN
    // One-byte prefetch buffer holding the next opcode and its address; flushed on redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_data  <= 8'h00;
            buf_pc    <= RESET_PC;
        end else if (redirect) begin
            buf_valid <= 1'b0;
        end else if (buf_fill) begin
            buf_valid <= 1'b1;
            buf_data  <= fetch_data;
            buf_pc    <= pc;
        end else if (buf_take) begin
            buf_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a byte memory,
// programmable wait-state bus responder and a small decode stub.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [23:0] fetch_addr;
    logic        fetch_ack;
    logic [7:0]  fetch_data;
    logic [7:0]  dec_opcode;
    logic [7:0]  dec_opext;
    logic        need_opext;
    logic        need_imm;
    logic        imm_size;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_opext;
    logic [15:0] instr_imm;
    logic [2:0]  instr_len;
    logic [23:0] instr_pc;
    logic        redirect;
    logic [23:0] redirect_pc;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  ext;
        logic [15:0] imm;
        logic [2:0]  len;
        logic [23:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  mem [logic [23:0]];
    int          checks = 0;
    int          errors = 0;
    int          accepts = 0;
    int          wait_states = 0;
    int          wait_cnt = 0;

    instr_fetch #(.RESET_PC(24'h000100)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ack    (fetch_ack),
        .fetch_data   (fetch_data),
        .dec_opcode   (dec_opcode),
        .dec_opext    (dec_opext),
        .need_opext   (need_opext),
        .need_imm     (need_imm),
        .imm_size     (imm_size),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_opext  (instr_opext),
        .instr_imm    (instr_imm),
        .instr_len    (instr_len),
        .instr_pc     (instr_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten memory reads back as the single-byte opcode 0x10.
    function automatic logic [7:0] mem_read(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h10;
    endfunction

    // Decode stub: 0x02 needs opext (imm16 when opext is 0x44), 0x20 imm8, 0x30 imm16, 0x50 opext only.
    always_comb begin
        need_opext = 1'b0;
        need_imm   = 1'b0;
        imm_size   = 1'b0;
        case (dec_opcode)
            8'h02: begin
                need_opext = 1'b1;
                if (dec_opext == 8'h44) begin
                    need_imm = 1'b1;
                    imm_size = 1'b1;
                end
            end
            8'h20: need_imm = 1'b1;
            8'h30: begin
                need_imm = 1'b1;
                imm_size = 1'b1;
            end
            8'h50: need_opext = 1'b1;
            default: ;
        endcase
    end

    // Bus responder: acks each request after wait_states idle cycles.
    initial begin
        fetch_ack  = 1'b0;
        fetch_data = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (reset || !fetch_req) begin
                fetch_ack  = 1'b0;
                fetch_data = 8'h00;
                wait_cnt   = 0;
            end else if (wait_cnt >= wait_states) begin
                fetch_ack  = 1'b1;
                fetch_data = mem_read(fetch_addr);
                wait_cnt   = 0;
            end else begin
                fetch_ack  = 1'b0;
                fetch_data = 8'h00;
                wait_cnt++;
            end
        end
    end

    // Scoreboard: every accepted instruction must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            accepts++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_accept: got pc %0h op %0h, required no instruction", instr_pc, instr_opcode);
            end else begin
                mon_e = exp_q.pop_front();
                checks += 5;
                if (instr_opcode !== mon_e.op) begin
                    errors++;
                    $display("[TB] FAIL sb_opcode: got %0h required %0h", instr_opcode, mon_e.op);
                end
                if (instr_opext !== mon_e.ext) begin
                    errors++;
                    $display("[TB] FAIL sb_opext: got %0h required %0h", instr_opext, mon_e.ext);
                end
                if (instr_imm !== mon_e.imm) begin
                    errors++;
                    $display("[TB] FAIL sb_imm: got %0h required %0h", instr_imm, mon_e.imm);
                end
                if (instr_len !== mon_e.len) begin
                    errors++;
                    $display("[TB] FAIL sb_len: got %0d required %0d", instr_len, mon_e.len);
                end
                if (instr_pc !== mon_e.pc) begin
                    errors++;
                    $display("[TB] FAIL sb_pc: got %0h required %0h", instr_pc, mon_e.pc);
                end
            end
        end
    end

    task automatic apply_reset(input int ws);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 24'h000000;
        wait_states = ws;
        mem.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        apply_reset(0);
        mem[24'h000100] = 8'h10;
        @(negedge clk);
        checks += 4;
        if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0d required 0", instr_valid); end
        if (instr_len !== 3'd1) begin errors++; $display("[TB] FAIL rst_len: got %0d required 1", instr_len); end
        if (instr_pc !== 24'h000100) begin errors++; $display("[TB] FAIL rst_pc: got %0h required 100", instr_pc); end
        if ({instr_opcode, instr_opext, instr_imm} !== 32'h0) begin errors++; $display("[TB] FAIL rst_fields: got %0h required 0", {instr_opcode, instr_opext, instr_imm}); end
        exp_q.push_back('{op: 8'h10, ext: 8'h00, imm: 16'h0000, len: 3'd1, pc: 24'h000100});
        exp_q.push_back('{op: 8'h10, ext: 8'h00, imm: 16'h0000, len: 3'd1, pc: 24'h000101});
        @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        checks += 3;
        if (fetch_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %0d required 1", fetch_req); end
        if (fetch_addr !== 24'h000100) begin errors++; $display("[TB] FAIL first_addr: got %0h required 100", fetch_addr); end
        if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_cycle1: got %0d required 0", instr_valid); end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL valid_cycle2: got %0d required 1", instr_valid); end
        @(negedge clk);
        checks += 2;
`ifdef IFETCH_PREFETCH_EN
        if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL valid_cycle3: got %0d required 1", instr_valid); end
        if (instr_pc !== 24'h000101) begin errors++; $display("[TB] FAIL pc_cycle3: got %0h required 101", instr_pc); end
`else
        if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_cycle3: got %0d required 0", instr_valid); end
        if (fetch_addr !== 24'h000101) begin errors++; $display("[TB] FAIL addr_cycle3: got %0h required 101", fetch_addr); end
`endif
        wait_empty(20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL reset_drain: got %0d pending required 0", exp_q.size()); end
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

    task automatic test_ext_imm16();
        bit ok;
        int cyc;
        apply_reset(0);
        mem[24'h000100] = 8'h02;
        mem[24'h000101] = 8'h44;
        mem[24'h000102] = 8'h34;
        mem[24'h000103] = 8'h12;
        mem[24'h000104] = 8'h10;
        exp_q.push_back('{op: 8'h02, ext: 8'h44, imm: 16'h1234, len: 3'd4, pc: 24'h000100});
        exp_q.push_back('{op: 8'h10, ext: 8'h00, imm: 16'h0000, len: 3'd1, pc: 24'h000104});
        reset       = 1'b0;
        instr_ready = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc != 5) begin errors++; $display("[TB] FAIL imm16_latency: got cycle %0d required 5", cyc); end
        wait_empty(40, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL imm16_drain: got %0d pending required 0", exp_q.size()); end
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

    task automatic test_mix();
        bit ok;
        apply_reset(1);
        mem[24'h000100] = 8'h20;
        mem[24'h000101] = 8'hAB;
        mem[24'h000102] = 8'h50;
        mem[24'h000103] = 8'h11;
        mem[24'h000104] = 8'h30;
        mem[24'h000105] = 8'hCD;
        mem[24'h000106] = 8'hEF;
        mem[24'h000107] = 8'h10;
        exp_q.push_back('{op: 8'h20, ext: 8'h00, imm: 16'h00AB, len: 3'd2, pc: 24'h000100});
        exp_q.push_back('{op: 8'h50, ext: 8'h11, imm: 16'h0000, len: 3'd2, pc: 24'h000102});
        exp_q.push_back('{op: 8'h30, ext: 8'h00, imm: 16'hEFCD, len: 3'd3, pc: 24'h000104});
        exp_q.push_back('{op: 8'h10, ext: 8'h00, imm: 16'h0000, len: 3'd1, pc: 24'h000107});
        reset       = 1'b0;
        instr_ready = 1'b1;
        wait_empty(100, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL mix_drain: got %0d pending required 0", exp_q.size()); end
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        bit ok;
        bit seen;
        bit prev_pending;
        logic [23:0] prev_addr;
        int base;
        apply_reset(3);
        mem[24'h000100] = 8'h30;
        mem[24'h000101] = 8'h34;
        mem[24'h000102] = 8'h12;
        mem[24'h000103] = 8'h10;
        exp_q.push_back('{op: 8'h30, ext: 8'h00, imm: 16'h1234, len: 3'd3, pc: 24'h000100});
        exp_q.push_back('{op: 8'h10, ext: 8'h00, imm: 16'h0000, len: 3'd1, pc: 24'h000103});
        reset        = 1'b0;
        seen         = 1'b0;
        prev_pending = 1'b0;
        prev_addr    = 24'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (prev_pending) begin
                checks++;
                if (fetch_req !== 1'b1 || fetch_addr !== prev_addr) begin
                    errors++;
                    $display("[TB] FAIL ws_addr_stable: got req %0d addr %0h required req 1 addr %0h", fetch_req, fetch_addr, prev_addr);
                end
            end
            prev_pending = fetch_req && !fetch_ack;
            prev_addr    = fetch_addr;
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL ws_valid_timeout: got valid 0 required 1"); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks += 2;
            if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL ws_hold_valid: got %0d required 1", instr_valid); end
            if ({instr_opcode, instr_opext, instr_imm, instr_len, instr_pc} !== {8'h30, 8'h00, 16'h1234, 3'd3, 24'h000100}) begin
                errors++;
                $display("[TB] FAIL ws_hold_fields: got op %0h imm %0h len %0d pc %0h required op 30 imm 1234 len 3 pc 100",
                         instr_opcode, instr_imm, instr_len, instr_pc);
            end
        end
        #1 base = accepts;
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (accepts != base + 1) begin errors++; $display("[TB] FAIL ws_one_accept: got %0d accepts required %0d", accepts - base, 1); end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        wait_empty(40, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL ws_drain: got %0d pending required 0", exp_q.size()); end
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

    task automatic test_redirect();
        bit ok;
        bit found;
        apply_reset(3);
        mem[24'h000100] = 8'h20;
        mem[24'h000101] = 8'h77;
        mem[24'h002000] = 8'h10;
        exp_q.push_back('{op: 8'h10, ext: 8'h00, imm: 16'h0000, len: 3'd1, pc: 24'h002000});
        reset       = 1'b0;
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_req === 1'b1 && fetch_addr === 24'h000101 && fetch_ack === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL redir_imm_wait: got no pending imm fetch, required one at 101"); end
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 24'h002000;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks += 2;
        if (fetch_req !== 1'b1) begin errors++; $display("[TB] FAIL drain_req: got %0d required 1", fetch_req); end
        if (fetch_addr !== 24'h000101) begin errors++; $display("[TB] FAIL drain_addr: got %0h required 101", fetch_addr); end
        for (int i = 0; i < 20; i++) begin
            if (fetch_addr !== 24'h000101) break;
            @(negedge clk);
        end
        checks++;
        if (fetch_addr !== 24'h002000) begin errors++; $display("[TB] FAIL redir_target: got %0h required 2000", fetch_addr); end
        wait_empty(40, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL redir_drain: got %0d pending required 0", exp_q.size()); end
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

    task automatic test_pc_wrap();
        bit ok;
        bit seen_top;
        bit checked;
        apply_reset(0);
        mem[24'hFFFFFF] = 8'h20;
        mem[24'h000000] = 8'h5A;
        exp_q.push_back('{op: 8'h20, ext: 8'h00, imm: 16'h005A, len: 3'd2, pc: 24'hFFFFFF});
        reset       = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 24'hFFFFFF;
        @(posedge clk);
        #1 redirect = 1'b0;
        seen_top = 1'b0;
        checked  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fetch_req === 1'b1 && fetch_addr === 24'hFFFFFF) begin
                seen_top = 1'b1;
            end else if (seen_top && fetch_req === 1'b1) begin
                checks++;
                checked = 1'b1;
                if (fetch_addr !== 24'h000000) begin errors++; $display("[TB] FAIL wrap_addr: got %0h required 0", fetch_addr); end
                break;
            end
        end
        checks++;
        if (!checked) begin errors++; $display("[TB] FAIL wrap_seen: got top %0d second %0d required 1 1", seen_top, checked); end
        wait_empty(20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL wrap_drain: got %0d pending required 0", exp_q.size()); end
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

`ifdef IFETCH_PREFETCH_EN
    task automatic test_prefetch();
        bit ok;
        bit seen;
        apply_reset(0);
        for (int i = 0; i < 10; i++)
            exp_q.push_back('{op: 8'h10, ext: 8'h00, imm: 16'h0000, len: 3'd1, pc: 24'h000100 + 24'(i)});
        reset       = 1'b0;
        instr_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL pf_first_valid: got 0 required 1"); end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            checks += 2;
            if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL pf_stream_valid: got %0d required 1", instr_valid); end
            if (instr_pc !== 24'h000100 + 24'(i)) begin errors++; $display("[TB] FAIL pf_stream_pc: got %0h required %0h", instr_pc, 24'h000100 + 24'(i)); end
        end
        @(posedge clk);
        #1 instr_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 24'h00010A) begin
                errors++;
                $display("[TB] FAIL pf_hold: got valid %0d pc %0h required 1 10a", instr_valid, instr_pc);
            end
        end
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{op: 8'h10, ext: 8'h00, imm: 16'h0000, len: 3'd1, pc: 24'h00010A + 24'(i)});
        @(posedge clk);
        #1 instr_ready = 1'b1;
        wait_empty(20, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL pf_drain: got %0d pending required 0", exp_q.size()); end
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask
`endif

    // Watchdog so the run always ends even if the DUT stalls somewhere unforeseen.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 24'h000000;
        test_reset();
        test_ext_imm16();
        test_mix();
        test_wait_states();
        test_redirect();
        test_pc_wrap();
`ifdef IFETCH_PREFETCH_EN
        test_prefetch();
`endif
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
